// File: rtl/serial_pe_pkg.sv
// serial_pe_pkg: shared constants and types for the serial PE sequencer.
//   - CTL_FIRST / CTL_LAST : bit positions inside the PE ctl field
//   - state_e              : sequencer FSM states
//   - OPND_W / RES_W       : PE operand and result widths
//   - relu()               : clamp of a signed result at zero
package serial_pe_pkg;

  localparam int CTL_FIRST = 0;
  localparam int CTL_LAST  = 1;
  localparam int OPND_W    = 16;
  localparam int RES_W     = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Negative results (sign bit set) are forced to zero.
  function automatic logic [RES_W-1:0] relu(input logic [RES_W-1:0] x);
    return x[RES_W-1] ? {RES_W{1'b0}} : x;
  endfunction

endpackage

// File: rtl/serial_pe_addr_gen.sv
// serial_pe_addr_gen: read address generator for the serial PE sequencer.
// Holds the k (element) and o (output) counters, the neuron and weight read
// addresses and the first/last-element flags for the read issued this cycle.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   load                  : accepted job; sample lengths and base addresses
//   step                  : a read pair is issued this cycle; advance
//   vec_len, out_num      : job geometry (sampled on load)
//   neuron_base/weight_base : base addresses (sampled on load)
//   neuron_addr/weight_addr : current read addresses
//   first, last_k, last_all : k==0, k==vec_len-1, and last read of the job
module serial_pe_addr_gen
  import serial_pe_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [LEN_W-1:0]  vec_len,
  input  logic [LEN_W-1:0]  out_num,
  input  logic [ADDR_W-1:0] neuron_base,
  input  logic [ADDR_W-1:0] weight_base,
  output logic [ADDR_W-1:0] neuron_addr,
  output logic [ADDR_W-1:0] weight_addr,
  output logic              first,
  output logic              last_k,
  output logic              last_all
);

  localparam logic [LEN_W-1:0]  LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]  LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADR_ZERO = {ADDR_W{1'b0}};

  logic [LEN_W-1:0]  r_k;
  logic [LEN_W-1:0]  r_o;
  logic [LEN_W-1:0]  r_vec_len;
  logic [LEN_W-1:0]  r_out_num;
  logic [ADDR_W-1:0] r_nbase;
  logic [ADDR_W-1:0] r_naddr;
  logic [ADDR_W-1:0] r_waddr;

  logic w_k_last;
  logic w_o_last;

  assign w_k_last = (r_k == (r_vec_len - LEN_ONE));
  assign w_o_last = (r_o == (r_out_num - LEN_ONE));

  assign neuron_addr = r_naddr;
  assign weight_addr = r_waddr;
  assign first       = (r_k == LEN_ZERO);
  assign last_k      = w_k_last;
  assign last_all    = w_k_last && w_o_last;

  // Counters and running addresses. The weight address is o*vec_len + k off
  // its base, which is simply the read index, so it just increments.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k       <= LEN_ZERO;
      r_o       <= LEN_ZERO;
      r_vec_len <= LEN_ZERO;
      r_out_num <= LEN_ZERO;
      r_nbase   <= ADR_ZERO;
      r_naddr   <= ADR_ZERO;
      r_waddr   <= ADR_ZERO;
    end else if (load) begin
      r_k       <= LEN_ZERO;
      r_o       <= LEN_ZERO;
      r_vec_len <= vec_len;
      r_out_num <= out_num;
      r_nbase   <= neuron_base;
      r_naddr   <= neuron_base;
      r_waddr   <= weight_base;
    end else if (step) begin
      r_waddr <= r_waddr + ADR_ONE;
      if (w_k_last) begin
        r_k     <= LEN_ZERO;
        r_o     <= r_o + LEN_ONE;
        r_naddr <= r_nbase;
      end else begin
        r_k     <= r_k + LEN_ONE;
        r_naddr <= r_naddr + ADR_ONE;
      end
    end else begin
      r_k <= r_k;
    end
  end

endmodule

// File: rtl/serial_pe_ctrl.sv
// serial_pe_ctrl: sequencer feeding one serial PE with neuron/weight pairs
// from two single-port SRAMs (1-cycle read latency) and storing each PE
// result into a result buffer.
// Ports:
//   clk, rst_n                : clock, async active-low reset
//   start, vec_len, out_num   : job request and geometry (sampled in IDLE)
//   neuron_base, weight_base, res_base : buffer base addresses
//   busy, done                : job in progress / one-cycle completion pulse
//   neuron_rd/addr/rdata, weight_rd/addr/rdata : operand SRAM reads
//   pe_neuron, pe_weight, pe_ctl, pe_vld       : PE operand interface
//   pe_result, pe_vld_o                        : PE result interface
//   res_we, res_addr, res_wdata                : result buffer write
// Build option: define SERIAL_PE_CTRL_RELU_EN to apply ReLU to written results.
module serial_pe_ctrl
  import serial_pe_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  vec_len,
  input  logic [LEN_W-1:0]  out_num,
  input  logic [ADDR_W-1:0] neuron_base,
  input  logic [ADDR_W-1:0] weight_base,
  input  logic [ADDR_W-1:0] res_base,
  output logic              busy,
  output logic              done,
  output logic              neuron_rd,
  output logic [ADDR_W-1:0] neuron_addr,
  input  logic [15:0]       neuron_rdata,
  output logic              weight_rd,
  output logic [ADDR_W-1:0] weight_addr,
  input  logic [15:0]       weight_rdata,
  output logic [15:0]       pe_neuron,
  output logic [15:0]       pe_weight,
  output logic [1:0]        pe_ctl,
  output logic              pe_vld,
  input  logic [31:0]       pe_result,
  input  logic              pe_vld_o,
  output logic              res_we,
  output logic [ADDR_W-1:0] res_addr,
  output logic [31:0]       res_wdata
);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_RUN   = RUN;
  localparam logic [1:0] S_DRAIN = DRAIN;
  localparam logic [1:0] S_DONE  = DONE;

  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [ADDR_W-1:0] r_res_base;
  logic [LEN_W-1:0]  r_out_num;
  logic [LEN_W-1:0]  r_wcnt;
  logic              r_pe_vld;
  logic [1:0]        r_pe_ctl;

  logic              w_start_ok;
  logic              w_zero_job;
  logic              w_load;
  logic              w_run;
  logic              w_res_we;
  logic [LEN_W:0]    w_wcnt_nxt;
  logic              w_first;
  logic              w_last_k;
  logic              w_last_all;

  assign w_start_ok = start && (r_state == S_IDLE);
  assign w_zero_job = (vec_len == LEN_ZERO) || (out_num == LEN_ZERO);
  assign w_load     = w_start_ok && !w_zero_job;
  assign w_run      = (r_state == S_RUN);
  // Results arriving outside an active job are dropped.
  assign w_res_we   = pe_vld_o && ((r_state == S_RUN) || (r_state == S_DRAIN));
  // Compare against the post-write count so DONE follows the last write
  // directly instead of one cycle later.
  assign w_wcnt_nxt = {1'b0, r_wcnt} + {{LEN_W{1'b0}}, w_res_we};

  serial_pe_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (w_load),
    .step        (w_run),
    .vec_len     (vec_len),
    .out_num     (out_num),
    .neuron_base (neuron_base),
    .weight_base (weight_base),
    .neuron_addr (neuron_addr),
    .weight_addr (weight_addr),
    .first       (w_first),
    .last_k      (w_last_k),
    .last_all    (w_last_all)
  );

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = w_zero_job ? S_DONE : S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN: begin
        if (w_last_all) begin
          w_state_nxt = S_DRAIN;
        end else begin
          w_state_nxt = S_RUN;
        end
      end
      S_DRAIN: begin
        if (w_wcnt_nxt == {1'b0, r_out_num}) begin
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_DRAIN;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State, job registers and write counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_res_base <= {ADDR_W{1'b0}};
      r_out_num  <= LEN_ZERO;
      r_wcnt     <= LEN_ZERO;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_ok) begin
        r_res_base <= res_base;
        r_out_num  <= out_num;
        r_wcnt     <= LEN_ZERO;
      end else if (w_res_we) begin
        r_wcnt <= r_wcnt + LEN_ONE;
      end else begin
        r_wcnt <= r_wcnt;
      end
    end
  end

  // PE valid/ctl follow the read by one cycle to line up with SRAM data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pe_vld <= 1'b0;
      r_pe_ctl <= 2'b00;
    end else begin
      r_pe_vld <= w_run;
      if (w_run) begin
        r_pe_ctl[CTL_FIRST] <= w_first;
        r_pe_ctl[CTL_LAST]  <= w_last_k;
      end else begin
        r_pe_ctl <= 2'b00;
      end
    end
  end

  assign busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done      = (r_state == S_DONE);
  assign neuron_rd = w_run;
  assign weight_rd = w_run;
  assign pe_neuron = neuron_rdata;
  assign pe_weight = weight_rdata;
  assign pe_vld    = r_pe_vld;
  assign pe_ctl    = r_pe_ctl;
  assign res_we    = w_res_we;
  assign res_addr  = r_res_base + ADDR_W'(r_wcnt);

`ifdef SERIAL_PE_CTRL_RELU_EN
  assign res_wdata = relu(pe_result);
`else
  assign res_wdata = pe_result;
`endif

endmodule

// File: tb/tb_serial_pe_ctrl.sv
module tb_serial_pe_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  vec_len;
  logic [7:0]  out_num;
  logic [9:0]  neuron_base;
  logic [9:0]  weight_base;
  logic [9:0]  res_base;
  logic        busy;
  logic        done;
  logic        neuron_rd;
  logic [9:0]  neuron_addr;
  logic [15:0] neuron_rdata;
  logic        weight_rd;
  logic [9:0]  weight_addr;
  logic [15:0] weight_rdata;
  logic [15:0] pe_neuron;
  logic [15:0] pe_weight;
  logic [1:0]  pe_ctl;
  logic        pe_vld;
  logic [31:0] pe_result;
  logic        pe_vld_o;
  logic        res_we;
  logic [9:0]  res_addr;
  logic [31:0] res_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  serial_pe_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vec_len(vec_len), .out_num(out_num),
    .neuron_base(neuron_base), .weight_base(weight_base), .res_base(res_base),
    .busy(busy), .done(done),
    .neuron_rd(neuron_rd), .neuron_addr(neuron_addr), .neuron_rdata(neuron_rdata),
    .weight_rd(weight_rd), .weight_addr(weight_addr), .weight_rdata(weight_rdata),
    .pe_neuron(pe_neuron), .pe_weight(pe_weight), .pe_ctl(pe_ctl), .pe_vld(pe_vld),
    .pe_result(pe_result), .pe_vld_o(pe_vld_o),
    .res_we(res_we), .res_addr(res_addr), .res_wdata(res_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM models, one-cycle read latency
  logic [15:0] nmem [0:1023];
  logic [15:0] wmem [0:1023];
  always @(posedge clk) begin
    if (neuron_rd) neuron_rdata <= nmem[neuron_addr];
    if (weight_rd) weight_rdata <= wmem[weight_addr];
  end

  // Serial PE model: signed MAC, result one cycle after the last element
  logic signed [31:0] acc;
  logic signed [31:0] prod;
  logic signed [31:0] acc_nxt;
  assign prod    = $signed(pe_neuron) * $signed(pe_weight);
  assign acc_nxt = pe_ctl[0] ? prod : acc + prod;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= 32'sd0; pe_result <= 32'd0; pe_vld_o <= 1'b0;
    end else begin
      pe_vld_o <= 1'b0;
      if (pe_vld) begin
        acc <= acc_nxt;
        if (pe_ctl[1]) begin
          pe_result <= acc_nxt;
          pe_vld_o  <= 1'b1;
        end
      end
    end
  end

  // Per-job observation log
  int wr_n, wr_cyc [0:7];
  logic [31:0] wr_addr [0:7];
  logic [31:0] wr_data [0:7];
  int wa_n;
  logic [31:0] wa_log [0:7];
  int done_cyc, busy_first, busy_last, busy_cnt, rd_cnt, vld_cnt, ctl_not11, done_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one job; cycle c is the cycle after edge E(c-1), E0 samples start.
  task automatic run_job(input int vl, input int on, input logic [9:0] nb,
                         input logic [9:0] wb, input logic [9:0] rb, input int again_cyc);
    wr_n = 0; wa_n = 0; done_cyc = -1; busy_first = -1; busy_last = -1;
    busy_cnt = 0; rd_cnt = 0; vld_cnt = 0; ctl_not11 = 0; done_busy = 0;
    for (int i = 0; i < 8; i++) begin
      wr_cyc[i] = -1; wr_addr[i] = 32'hDEAD; wr_data[i] = 32'hDEAD; wa_log[i] = 32'hDEAD;
    end
    @(negedge clk);
    vec_len = vl[7:0]; out_num = on[7:0];
    neuron_base = nb; weight_base = wb; res_base = rb; start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      start = (c == again_cyc) ? 1'b1 : 1'b0;
      if (res_we && wr_n < 8) begin
        wr_cyc[wr_n] = c; wr_addr[wr_n] = {22'd0, res_addr}; wr_data[wr_n] = res_wdata; wr_n++;
      end
      if (done && done_cyc < 0) done_cyc = c;
      if (done && busy) done_busy++;
      if (busy) begin
        if (busy_first < 0) busy_first = c;
        busy_last = c; busy_cnt++;
      end
      if (neuron_rd) begin
        if (wa_n < 8) wa_log[wa_n] = {22'd0, weight_addr};
        wa_n++; rd_cnt++;
      end
      if (pe_vld) begin
        vld_cnt++;
        if (pe_ctl != 2'b11) ctl_not11++;
      end
    end
  endtask

  task automatic check_job1(input string p);
    chk({p, "_wr_n"}, wr_n, 32'd2);
    chk({p, "_wr0_cyc"}, wr_cyc[0], 32'd5);
    chk({p, "_wr0_addr"}, wr_addr[0], 32'd100);
    chk({p, "_wr0_data"}, wr_data[0], 32'd32);
    chk({p, "_wr1_cyc"}, wr_cyc[1], 32'd8);
    chk({p, "_wr1_addr"}, wr_addr[1], 32'd101);
`ifdef SERIAL_PE_CTRL_RELU_EN
    chk({p, "_wr1_data"}, wr_data[1], 32'd0);
`else
    chk({p, "_wr1_data"}, wr_data[1], 32'hFFFF_FFF2);
`endif
    chk({p, "_done_cyc"}, done_cyc, 32'd9);
    chk({p, "_busy_first"}, busy_first, 32'd1);
    chk({p, "_busy_last"}, busy_last, 32'd8);
    chk({p, "_busy_cnt"}, busy_cnt, 32'd8);
    chk({p, "_done_busy"}, done_busy, 32'd0);
    chk({p, "_rd_cnt"}, rd_cnt, 32'd6);
    chk({p, "_vld_cnt"}, vld_cnt, 32'd6);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; vec_len = 8'd0; out_num = 8'd0;
    neuron_base = 10'd0; weight_base = 10'd0; res_base = 10'd0;
    for (int i = 0; i < 1024; i++) begin nmem[i] = 16'd0; wmem[i] = 16'd0; end
    nmem[10] = 16'd1; nmem[11] = 16'd2; nmem[12] = 16'd3;
    wmem[20] = 16'd4; wmem[21] = 16'd5; wmem[22] = 16'd6;
    wmem[23] = 16'hFFFF; wmem[24] = 16'hFFFE; wmem[25] = 16'hFFFD;
    nmem[0] = 16'd7;
    wmem[40] = 16'd1; wmem[41] = 16'd2; wmem[42] = 16'hFFFD; wmem[43] = 16'd4;
    for (int i = 50; i < 54; i++) nmem[i] = 16'd1;
    wmem[1022] = 16'd1; wmem[1023] = 16'd2; wmem[0] = 16'd3; wmem[1] = 16'd4;

    // reset values
    #13;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_rd", {30'd0, neuron_rd, weight_rd}, 32'd0);
    chk("rst_pe", {29'd0, pe_vld, pe_ctl}, 32'd0);
    chk("rst_res_we", {31'd0, res_we}, 32'd0);
    chk("rst_addrs", {2'd0, neuron_addr, weight_addr, res_addr}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // vec_len=3, out_num=2
    run_job(3, 2, 10'd10, 10'd20, 10'd100, 0);
    check_job1("j1");

    // vec_len=1, out_num=4: every element is first and last
    run_job(1, 4, 10'd0, 10'd40, 10'd200, 0);
    chk("j2_wr_n", wr_n, 32'd4);
    chk("j2_wr0_cyc", wr_cyc[0], 32'd3);
    chk("j2_wr3_cyc", wr_cyc[3], 32'd6);
    chk("j2_wr3_addr", wr_addr[3], 32'd203);
    chk("j2_wr1_data", wr_data[1], 32'd14);
`ifdef SERIAL_PE_CTRL_RELU_EN
    chk("j2_wr2_data", wr_data[2], 32'd0);
`else
    chk("j2_wr2_data", wr_data[2], 32'hFFFF_FFEB);
`endif
    chk("j2_wr3_data", wr_data[3], 32'd28);
    chk("j2_vld_cnt", vld_cnt, 32'd4);
    chk("j2_ctl_not11", ctl_not11, 32'd0);
    chk("j2_done_cyc", done_cyc, 32'd7);

    // zero-length jobs
    run_job(0, 5, 10'd10, 10'd20, 10'd100, 0);
    chk("z1_done_cyc", done_cyc, 32'd1);
    chk("z1_activity", rd_cnt + vld_cnt + wr_n + busy_cnt, 32'd0);
    run_job(4, 0, 10'd10, 10'd20, 10'd100, 0);
    chk("z2_done_cyc", done_cyc, 32'd1);
    chk("z2_activity", rd_cnt + vld_cnt + wr_n + busy_cnt, 32'd0);

    // start pulsed again in cycle 2: ignored
    run_job(3, 2, 10'd10, 10'd20, 10'd100, 2);
    check_job1("j1s");

    // reset dropped in cycle 3 of a job
    @(negedge clk);
    vec_len = 8'd3; out_num = 8'd2; neuron_base = 10'd10; weight_base = 10'd20;
    res_base = 10'd100; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mr_busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_busy", {31'd0, busy}, 32'd0);
    chk("mr_done", {31'd0, done}, 32'd0);
    chk("mr_rd", {30'd0, neuron_rd, weight_rd}, 32'd0);
    chk("mr_pe", {29'd0, pe_vld, pe_ctl}, 32'd0);
    chk("mr_addrs", {2'd0, neuron_addr, weight_addr, res_addr}, 32'd0);
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    run_job(3, 2, 10'd10, 10'd20, 10'd100, 0);
    check_job1("j1r");

    // weight address wrap
    run_job(4, 1, 10'd50, 10'd1022, 10'd300, 0);
    chk("wrap_rd_cnt", rd_cnt, 32'd4);
    chk("wrap_wa0", wa_log[0], 32'd1022);
    chk("wrap_wa1", wa_log[1], 32'd1023);
    chk("wrap_wa2", wa_log[2], 32'd0);
    chk("wrap_wa3", wa_log[3], 32'd1);
    chk("wrap_wr_data", wr_data[0], 32'd10);
    chk("wrap_wr_cyc", wr_cyc[0], 32'd6);
    chk("wrap_done_cyc", done_cyc, 32'd7);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_pe_ctrl.md
# serial_pe_ctrl

Sequencer that drives a single serial PE with a stream of neuron/weight pairs and stores its results. It reads both operands from single-port SRAMs with one-cycle read latency and drives the PE's `neuron`/`weight`/`ctl`/`vld_i` inputs, producing the ctl framing the PE expects. It captures each accumulated result when the PE raises `vld_o` and writes it to a result buffer. It sits between the layer-level scheduler (start/done) and one PE instance.

## Interface
Parameters:
- `ADDR_W`, 10, address width of neuron, weight and result buffers
- `LEN_W`, 8, width of `vec_len` and `out_num`

Ports:
- `clk` in 1: single clock, all logic on rising edge
- `rst_n` in 1: reset, asynchronous, active-low
- `start` in 1: one-cycle job request, honoured only in IDLE
- `vec_len` in LEN_W: MACs per output (unsigned), sampled with `start`
- `out_num` in LEN_W: outputs per job (unsigned), sampled with `start`
- `neuron_base`, `weight_base`, `res_base` in ADDR_W each: base addresses, sampled with `start`
- `busy` out 1: job in progress
- `done` out 1: one-cycle pulse at job completion
- `neuron_rd` out 1, `neuron_addr` out ADDR_W: neuron SRAM read
- `neuron_rdata` in 16: neuron data, valid the cycle after `neuron_rd`
- `weight_rd` out 1, `weight_addr` out ADDR_W: weight SRAM read
- `weight_rdata` in 16: weight data, valid the cycle after `weight_rd`
- `pe_neuron` out 16, `pe_weight` out 16: operands to the PE
- `pe_ctl` out 2: bit0 = first element (clear accumulator), bit1 = last element (emit result)
- `pe_vld` out 1: operand valid to the PE
- `pe_result` in 32, `pe_vld_o` in 1: result from the PE
- `res_we` out 1, `res_addr` out ADDR_W, `res_wdata` out 32: result buffer write

## Operation
- **FSM states:** IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on `start` when `vec_len` ≠ 0 and `out_num` ≠ 0.
  - IDLE → DONE on `start` when either is 0. No reads or writes occur.
  - RUN → DRAIN after the read with k = `vec_len`-1 and o = `out_num`-1 is issued.
  - DRAIN → DONE when the write count equals `out_num`.
  - DONE → IDLE unconditionally.
- **Read addressing in RUN:** one read pair per cycle, with `neuron_rd` = `weight_rd` = 1.
  - k counts 0..`vec_len`-1 and o counts 0..`out_num`-1.
  - `neuron_addr` = `neuron_base` + k.
  - `weight_addr` = `weight_base` + o·`vec_len` + k, generated by a running counter (no multiplier).
  - All addresses wrap modulo 2^ADDR_W.
- **PE drive:**
  - `pe_vld` is `neuron_rd` delayed one cycle. `pe_ctl` is delayed the same way.
  - `pe_ctl[0]` = (k==0) and `pe_ctl[1]` = (k==`vec_len`-1). With `vec_len`=1 every element carries `pe_ctl` = 2'b11.
  - `pe_neuron` = `neuron_rdata` and `pe_weight` = `weight_rdata`, passed combinationally.
  - When `pe_vld` = 0, `pe_ctl` = 0.
- **Result capture:**
  - `res_we` = `pe_vld_o`, combinational.
  - `res_addr` = `res_base` + write count.
  - `res_wdata` = `pe_result`, or its ReLU (see Configuration).
  - The write count increments on each `res_we`.
- **Ignored inputs:**
  - `start` outside IDLE is ignored.
  - `pe_vld_o` outside RUN/DRAIN is ignored: no write.
- **Reset** (asserted at any time, including mid-job): returns to IDLE and clears all counters.
  - Reset values: `busy`, `done`, `neuron_rd`, `weight_rd`, `pe_vld`, `res_we` = 0; `pe_ctl` = 0; all addresses = 0.

## Timing
- `start` is sampled at edge E0. Cycle n is the cycle following edge E(n-1).
- Reads occur in cycles 1..N, where N = `vec_len`·`out_num`. Reads are back-to-back with no bubbles between outputs.
- The PE is fed in cycles 2..N+1.
- The write for output o occurs in cycle (o+1)·`vec_len`+2. The first write is at cycle `vec_len`+2 and the last at N+2.
- `busy` is high in cycles 1..N+2. `done` is high in cycle N+3, with `busy` low. IDLE resumes at cycle N+4, and a new `start` is accepted in cycle N+4.
- Zero-length job: `done` in cycle 1, `busy` never asserted.

## Configuration
- Macro `SERIAL_PE_CTRL_RELU_EN`.
- Defined: `res_wdata` = 0 when `pe_result[31]` = 1, otherwise `pe_result`.
- Undefined: `res_wdata` = `pe_result` unmodified.
- Timing is identical in both builds.

## Structure
- Package `serial_pe_pkg` holds:
  - the ctl bit index constants (CTL_FIRST=0, CTL_LAST=1);
  - the state enum {IDLE, RUN, DRAIN, DONE};
  - operand width 16 and result width 32.
- One sub-module, `serial_pe_addr_gen`, holds the k/o counters, the running weight address and the last-element flags.
- The FSM, delay registers and write path live in `serial_pe_ctrl`.

## Test plan
- `vec_len`=3, `out_num`=2, neurons {1,2,3}, weights {4,5,6,-1,-2,-3}, PE model attached.
  - Writes 32 at `res_base` in cycle 5 and -14 at `res_base`+1 in cycle 8.
  - `done` in cycle 9.
  - With `SERIAL_PE_CTRL_RELU_EN`, the second write is 0.
- `vec_len`=1, `out_num`=4: every `pe_vld` cycle carries `pe_ctl`=2'b11; writes occur in cycles 3..6; `done` in cycle 7.
- `vec_len`=0 or `out_num`=0: `done` in cycle 1; no read, PE or write activity.
- `start` pulsed in cycle 2 of a job: ignored, and the job completes with unchanged timing.
- `rst_n` dropped in cycle 3 of a job: all outputs return to reset values immediately; a new `start` after release runs a full job correctly.
- `weight_base`=2^ADDR_W-2, `vec_len`=4: `weight_addr` sequence is 1022, 1023, 0, 1 for ADDR_W=10.
